sseg_reader: RTL and testbench
==============================

# sseg_reader

Receive-side checker for the adder-with-display datapath. It samples the 7-bit segment bus and the reference sum `{CO,S}`, and waits until the segment pattern has been stable for a programmable number of cycles. It then decodes the pattern back to a hex digit and flags illegal patterns or a disagreement with the reference sum. It sits after the adder/display block, on the bench or on the board, as a self-check and readback path.

## Interface
- `STABLE_CYCLES`, 4: consecutive equal samples required before a pattern is accepted; legal range 1..15.
- `ACTIVE_LOW`, 0: 1 means segments are lit-low, and the input is inverted before decode.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `SSeg`  in  7  segment bus; bit0=a … bit6=g.
- `S`  in  3  reference sum bits from the adder.
- `CO`  in  1  reference carry; the reference value is `{CO,S}` (0..15).
- `digit`  out  4  last accepted decoded digit.
- `valid`  out  1  high while in LOCKED.
- `new_pulse`  out  1  one-cycle strobe on each acceptance of a legal pattern.
- `seg_err`  out  1  high while in BAD (stable illegal pattern).
- `mismatch`  out  1  registered at acceptance: `digit != {CO,S}`; held until the next acceptance or until blank.
- `upd_cnt`  out  8  number of legal acceptances; wraps 255→0.

## Operation
- Input stage: `p = ACTIVE_LOW ? ~SSeg : SSeg`. `p` and `{CO,S}` are registered every cycle into `r_p` and `r_ref`.
- Legal decode (active-high, hex value→pattern):
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
  - 00 is BLANK.
  - Any other pattern is illegal.
- Stability counter `stab` (4 bits):
  - Cleared to 0 when `p != r_p`.
  - Otherwise it increments, saturating at `STABLE_CYCLES`.
  - A pattern is "stable" when `stab == STABLE_CYCLES-1` and `p == r_p`. This is the acceptance edge.
- State machine:
  - IDLE (reset state): on a stable non-blank pattern, go to LOCKED if legal or BAD if illegal.
  - SETTLE: entered from LOCKED or BAD whenever `p != r_p`. On the acceptance edge:
    - legal → LOCKED;
    - illegal → BAD;
    - blank → IDLE.
  - LOCKED: `valid=1`, `digit` held. A change of pattern → SETTLE, with `valid` dropping on that same edge.
  - BAD: `seg_err=1`. A change of pattern → SETTLE, with `seg_err` dropping on that same edge.
- On entering LOCKED:
  - `digit` ← decoded value;
  - `new_pulse=1` for exactly one cycle;
  - `upd_cnt` += 1;
  - `mismatch` ← (decoded != `r_ref`).
- Re-acceptance of the same value after a glitch is a new acceptance: a new pulse, and `upd_cnt` increments.
- Entering IDLE from SETTLE (stable blank):
  - clears `mismatch`;
  - `digit` keeps its last value;
  - `valid=0`, `seg_err=0`.
- `{CO,S}` affects only `mismatch`. It never affects state.

## Timing
- Reset (async assert, sync-free release) sets:
  - `state=IDLE`, `r_p=0`, `r_ref=0`, `stab=0`;
  - `digit=0`, `valid=0`, `new_pulse=0`, `seg_err=0`, `mismatch=0`, `upd_cnt=0`.
- Assertion of `rst_n` mid-operation clears all of the above immediately, without waiting for a clock edge.
- Latency: `SSeg` changes before edge k and then stays constant. `valid`/`new_pulse` (or `seg_err`) rise after edge k+STABLE_CYCLES.
- With `STABLE_CYCLES=1`, acceptance occurs on the first edge with `p == r_p`.
- A pattern change on any edge before acceptance restarts the count. There is no partial credit.
- Mismatch sampling: `mismatch` uses `r_ref` registered on the acceptance edge minus one. This is the same sample alignment as `r_p`.
- `upd_cnt` wraps from 255 to 0 and is not saturating. `new_pulse` is still issued on the wrapping acceptance.

## Test plan
1. Reset, then hold `SSeg`=7D (digit 6) and `{CO,S}`=6. Required with `STABLE_CYCLES`=4:
   - `valid`/`new_pulse`=1 after the 4th edge;
   - `digit`=6, `mismatch`=0, `upd_cnt`=1;
   - `new_pulse`=0 on the next cycle.
2. Hold `SSeg`=71 (F) with `{CO,S}`=14 → at acceptance `digit`=F and `mismatch`=1. Then hold 79 (E) with ref 14 → `mismatch`=0 and `upd_cnt` advances by 2 in total.
3. Glitch: alternate `SSeg` 06/5B every 2 cycles for 20 cycles, then hold 5B → no `new_pulse` during the toggling, and a single acceptance with `digit`=2 four edges after the hold begins.
4. Illegal pattern: hold `SSeg`=01 → `seg_err`=1 after 4 edges, with `valid`=0 and `upd_cnt` unchanged. Then hold 00 → `seg_err` falls and the block returns to IDLE with `mismatch`=0.
5. `ACTIVE_LOW`=1: drive `SSeg`=~3F=40 → `digit`=0 and `valid`=1. Assert `rst_n`=0 mid-SETTLE → all outputs 0 immediately. Release and hold 40 → acceptance after 4 edges.
6. Drive 256 alternating legal acceptances (06/5B, each held 5 cycles) → `upd_cnt` wraps to 0 with `new_pulse` seen 256 times.

Source files
------------

// File: rtl/sseg_reader_if.sv
// -----------------------------------------------------------------------------
// sseg_reader_if
//   Bundles the segment/reference inputs and the readback status outputs of
//   sseg_reader so the checker can be dropped next to an adder/display block
//   as a single connection.
//
//   master : the side that produces segment/reference values and observes
//            the readback (bench or board-level wrapper).
//   slave  : the sseg_reader itself.
//
//   Signals
//     SSeg      7  segment bus, bit0=a .. bit6=g
//     S         3  reference sum bits from the adder
//     CO        1  reference carry; reference value is {CO,S}
//     digit     4  last accepted decoded digit
//     valid     1  high while a legal pattern is locked
//     new_pulse 1  one-cycle strobe per legal acceptance
//     seg_err   1  high while a stable illegal pattern is held
//     mismatch  1  decoded digit disagreed with {CO,S} at acceptance
//     upd_cnt   8  count of legal acceptances (wrapping)
// -----------------------------------------------------------------------------
interface sseg_reader_if;
  logic [6:0] SSeg;
  logic [2:0] S;
  logic       CO;
  logic [3:0] digit;
  logic       valid;
  logic       new_pulse;
  logic       seg_err;
  logic       mismatch;
  logic [7:0] upd_cnt;

  modport master (
    output SSeg, S, CO,
    input  digit, valid, new_pulse, seg_err, mismatch, upd_cnt
  );

  modport slave (
    input  SSeg, S, CO,
    output digit, valid, new_pulse, seg_err, mismatch, upd_cnt
  );
endinterface

// File: rtl/sseg_reader.sv
// -----------------------------------------------------------------------------
// sseg_reader
//   Receive-side checker for the adder-with-display datapath. Waits until the
//   7-segment pattern has been stable for STABLE_CYCLES consecutive samples,
//   decodes it back to a hex digit, and flags illegal patterns or a
//   disagreement with the reference sum {CO,S}.
//
//   Parameters
//     STABLE_CYCLES  consecutive equal samples before acceptance (1..15)
//     ACTIVE_LOW     1 = segments lit-low; input is inverted before decode
//
//   Ports
//     clk    in  single clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    slave side of sseg_reader_if (SSeg/S/CO in, status out)
// -----------------------------------------------------------------------------
module sseg_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  sseg_reader_if.slave  bus
);

  localparam logic [3:0] STAB_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2,
    ST_BAD    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] r_p_q;
  logic [3:0] r_ref_q;
  logic [3:0] stab_q, stab_d;
  logic [3:0] digit_q, digit_d;
  logic       new_pulse_q, new_pulse_d;
  logic       mismatch_q, mismatch_d;
  logic [7:0] upd_cnt_q, upd_cnt_d;

  logic [6:0] p_w;
  logic       changed_w;
  logic       accept_w;
  logic [3:0] dec_val_w;
  logic       dec_legal_w;
  logic       dec_blank_w;

  // Normalise polarity so the decode table is always active-high.
  assign p_w       = ACTIVE_LOW ? ~bus.SSeg : bus.SSeg;
  assign changed_w = (p_w != r_p_q);

  // Acceptance edge: the current sample matches the previous one and enough
  // matching samples have already been counted.
  assign accept_w  = !changed_w && (stab_q == STAB_LAST);

  // Count resets on any change; saturates so a held pattern is accepted once.
  always_comb begin
    stab_d = stab_q;
    if (changed_w) begin
      stab_d = 4'd0;
    end else if (stab_q < STAB_MAX) begin
      stab_d = stab_q + 4'd1;
    end
  end

  // Decode the registered pattern. At acceptance p == r_p, so r_p is the
  // pattern being accepted.
  always_comb begin
    dec_val_w   = 4'h0;
    dec_legal_w = 1'b1;
    dec_blank_w = 1'b0;
    unique case (r_p_q)
      7'h3F: dec_val_w = 4'h0;
      7'h06: dec_val_w = 4'h1;
      7'h5B: dec_val_w = 4'h2;
      7'h4F: dec_val_w = 4'h3;
      7'h66: dec_val_w = 4'h4;
      7'h6D: dec_val_w = 4'h5;
      7'h7D: dec_val_w = 4'h6;
      7'h07: dec_val_w = 4'h7;
      7'h7F: dec_val_w = 4'h8;
      7'h6F: dec_val_w = 4'h9;
      7'h77: dec_val_w = 4'hA;
      7'h7C: dec_val_w = 4'hB;
      7'h39: dec_val_w = 4'hC;
      7'h5E: dec_val_w = 4'hD;
      7'h79: dec_val_w = 4'hE;
      7'h71: dec_val_w = 4'hF;
      7'h00: begin
        dec_legal_w = 1'b0;
        dec_blank_w = 1'b1;
      end
      default: dec_legal_w = 1'b0;
    endcase
  end

  // Next-state and acceptance side effects.
  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    new_pulse_d = 1'b0;
    mismatch_d  = mismatch_q;
    upd_cnt_d   = upd_cnt_q;

    unique case (state_q)
      ST_IDLE, ST_SETTLE: begin
        if (accept_w) begin
          if (dec_blank_w) begin
            // Blank returns to IDLE; the last digit is kept for readback.
            state_d    = ST_IDLE;
            mismatch_d = 1'b0;
          end else if (dec_legal_w) begin
            state_d     = ST_LOCKED;
            digit_d     = dec_val_w;
            new_pulse_d = 1'b1;
            upd_cnt_d   = upd_cnt_q + 8'd1;
            mismatch_d  = (dec_val_w != r_ref_q);
          end else begin
            state_d = ST_BAD;
          end
        end
      end
      ST_LOCKED, ST_BAD: begin
        if (changed_w) begin
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      r_p_q       <= 7'h00;
      r_ref_q     <= 4'h0;
      stab_q      <= 4'd0;
      digit_q     <= 4'h0;
      new_pulse_q <= 1'b0;
      mismatch_q  <= 1'b0;
      upd_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      r_p_q       <= p_w;
      r_ref_q     <= {bus.CO, bus.S};
      stab_q      <= stab_d;
      digit_q     <= digit_d;
      new_pulse_q <= new_pulse_d;
      mismatch_q  <= mismatch_d;
      upd_cnt_q   <= upd_cnt_d;
    end
  end

  assign bus.digit     = digit_q;
  assign bus.valid     = (state_q == ST_LOCKED);
  assign bus.seg_err   = (state_q == ST_BAD);
  assign bus.new_pulse = new_pulse_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.upd_cnt   = upd_cnt_q;

endmodule

// File: tb/tb_sseg_reader.sv
// -----------------------------------------------------------------------------
// tb_sseg_reader
//   Directed bench for sseg_reader. dut1 is active-high, dut2 is active-low;
//   both use STABLE_CYCLES=4. A pattern driven just after edge k-1 is first
//   sampled at edge k and accepted at edge k+4.
// -----------------------------------------------------------------------------
module tb_sseg_reader;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  sseg_reader_if bus1 ();
  sseg_reader_if bus2 ();

  sseg_reader #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  sseg_reader #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  int errors = 0;
  int checks = 0;
  int pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Drive dut1 and advance to just after edge k+3 (one edge before acceptance).
  task automatic drive1(input logic [6:0] seg, input logic [3:0] refv);
    bus1.SSeg = seg;
    {bus1.CO, bus1.S} = refv;
    ticks(4);
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    bus1.SSeg = 7'h00; bus1.S = 3'd0; bus1.CO = 1'b0;
    bus2.SSeg = 7'h7F; bus2.S = 3'd0; bus2.CO = 1'b0;  // blank when lit-low
    #12;
    chk("rst_digit",    32'(bus1.digit),     0);
    chk("rst_valid",    32'(bus1.valid),     0);
    chk("rst_pulse",    32'(bus1.new_pulse), 0);
    chk("rst_seg_err",  32'(bus1.seg_err),   0);
    chk("rst_mismatch", 32'(bus1.mismatch),  0);
    chk("rst_upd_cnt",  32'(bus1.upd_cnt),   0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    tick();

    // 1: digit 6 with matching reference
    drive1(7'h7D, 4'd6);
    chk("t1_pulse_early", 32'(bus1.new_pulse), 0);
    chk("t1_valid_early", 32'(bus1.valid),     0);
    tick();
    chk("t1_pulse",    32'(bus1.new_pulse), 1);
    chk("t1_valid",    32'(bus1.valid),     1);
    chk("t1_digit",    32'(bus1.digit),     6);
    chk("t1_mismatch", 32'(bus1.mismatch),  0);
    chk("t1_upd_cnt",  32'(bus1.upd_cnt),   1);
    tick();
    chk("t1_pulse_drop", 32'(bus1.new_pulse), 0);
    chk("t1_valid_hold", 32'(bus1.valid),     1);

    // 2: F against ref 14 mismatches, E against ref 14 matches
    drive1(7'h71, 4'd14);
    chk("t2_valid_settle", 32'(bus1.valid), 0);
    tick();
    chk("t2_digit_f",    32'(bus1.digit),     15);
    chk("t2_mismatch_f", 32'(bus1.mismatch),  1);
    chk("t2_pulse_f",    32'(bus1.new_pulse), 1);
    drive1(7'h79, 4'd14);
    tick();
    chk("t2_digit_e",    32'(bus1.digit),    14);
    chk("t2_mismatch_e", 32'(bus1.mismatch), 0);
    chk("t2_upd_cnt",    32'(bus1.upd_cnt),  3);

    // 3: toggling never reaches acceptance; then hold 5B with ref 0
    pulses = 0;
    {bus1.CO, bus1.S} = 4'd0;
    for (int i = 0; i < 10; i++) begin
      bus1.SSeg = (i % 2 == 0) ? 7'h5B : 7'h06;
      repeat (2) begin
        tick();
        if (bus1.new_pulse) pulses++;
      end
    end
    chk("t3_toggle_pulses", 32'(pulses),     0);
    chk("t3_toggle_valid",  32'(bus1.valid), 0);
    drive1(7'h5B, 4'd0);
    chk("t3_pulse_early", 32'(bus1.new_pulse), 0);
    tick();
    chk("t3_pulse",    32'(bus1.new_pulse), 1);
    chk("t3_digit",    32'(bus1.digit),     2);
    chk("t3_mismatch", 32'(bus1.mismatch),  1);
    chk("t3_upd_cnt",  32'(bus1.upd_cnt),   4);

    // 4: illegal pattern, then blank back to IDLE
    drive1(7'h01, 4'd0);
    chk("t4_seg_err_early", 32'(bus1.seg_err), 0);
    tick();
    chk("t4_seg_err",  32'(bus1.seg_err),   1);
    chk("t4_valid",    32'(bus1.valid),     0);
    chk("t4_pulse",    32'(bus1.new_pulse), 0);
    chk("t4_upd_cnt",  32'(bus1.upd_cnt),   4);
    chk("t4_mm_held",  32'(bus1.mismatch),  1);
    drive1(7'h00, 4'd0);
    chk("t4_seg_err_drop", 32'(bus1.seg_err),  0);
    chk("t4_mm_pre_idle",  32'(bus1.mismatch), 1);
    tick();
    chk("t4_mm_idle",    32'(bus1.mismatch), 0);
    chk("t4_valid_idle", 32'(bus1.valid),    0);
    chk("t4_digit_kept", 32'(bus1.digit),    2);

    // 5: active-low instance, async reset mid-SETTLE
    bus2.SSeg = 7'h40;
    ticks(4);
    chk("t5_valid_early", 32'(bus2.valid), 0);
    tick();
    chk("t5_valid",   32'(bus2.valid),     1);
    chk("t5_digit",   32'(bus2.digit),     0);
    chk("t5_pulse",   32'(bus2.new_pulse), 1);
    chk("t5_upd_cnt", 32'(bus2.upd_cnt),   1);
    bus2.SSeg = 7'h79;  // lit-low 1
    ticks(2);
    chk("t5_settle_valid", 32'(bus2.valid), 0);
    #2;
    rst2_n = 1'b0;
    #1;
    chk("t5_rst_digit",    32'(bus2.digit),     0);
    chk("t5_rst_valid",    32'(bus2.valid),     0);
    chk("t5_rst_pulse",    32'(bus2.new_pulse), 0);
    chk("t5_rst_seg_err",  32'(bus2.seg_err),   0);
    chk("t5_rst_mismatch", 32'(bus2.mismatch),  0);
    chk("t5_rst_upd_cnt",  32'(bus2.upd_cnt),   0);
    bus2.SSeg = 7'h40;
    rst2_n = 1'b1;
    ticks(4);
    chk("t5_re_pulse_early", 32'(bus2.new_pulse), 0);
    tick();
    chk("t5_re_valid",   32'(bus2.valid),     1);
    chk("t5_re_pulse",   32'(bus2.new_pulse), 1);
    chk("t5_re_upd_cnt", 32'(bus2.upd_cnt),   1);

    // 6: 256 acceptances wrap upd_cnt back to 0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    chk("t6_rst_upd_cnt", 32'(bus1.upd_cnt), 0);
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      bus1.SSeg = (i % 2 == 0) ? 7'h06 : 7'h5B;
      repeat (5) begin
        tick();
        if (bus1.new_pulse) pulses++;
      end
      if (i == 254) chk("t6_upd_cnt_255", 32'(bus1.upd_cnt), 255);
    end
    chk("t6_pulses",     32'(pulses),          256);
    chk("t6_upd_wrap",   32'(bus1.upd_cnt),    0);
    chk("t6_wrap_pulse", 32'(bus1.new_pulse),  1);
    chk("t6_digit",      32'(bus1.digit),      2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
